// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter/sequencer sharing one St/Done/Idle multiplier among N_REQ requesters.
// Optional watchdog abort of a stalled multiply is enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_arbiter #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned W       = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [N_REQ-1:0]   Req,
    input  logic [N_REQ*W-1:0] OpA,
    input  logic [N_REQ*W-1:0] OpB,
    output logic [N_REQ-1:0]   Gnt,
    output logic [N_REQ-1:0]   Ack,
    output logic [2*W-1:0]     Result,
    output logic               Err,
    output logic               Busy,
    output logic               Mul_St,
    output logic [W-1:0]       Mul_A,
    output logic [W-1:0]       Mul_B,
    input  logic               Mul_Done,
    input  logic               Mul_Idle,
    input  logic [2*W-1:0]     Mul_Produto
);

    localparam int unsigned IW = $clog2(N_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP,
        S_CLEAR
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      win_q, win_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [2*W-1:0]     res_q, res_d;

    logic [IW-1:0]      pick;
    logic [IW-1:0]      cand;
    logic               found;
    logic [W-1:0]       sel_a;
    logic [W-1:0]       sel_b;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d;
`endif

    // Search starts one past the last winner and wraps, giving round-robin fairness.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IW'((32'(ptr_q) + k) % N_REQ);
            if (!found && Req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick == IW'(i)) begin
                sel_a = OpA[i*W +: W];
                sel_b = OpB[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
`ifdef MUL_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (found && Mul_Idle) begin
                    win_d   = pick;
                    gnt_d   = N_REQ'(1) << pick;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    state_d = S_START;
                end
            end
            S_START: begin
`ifdef MUL_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (Mul_Done) begin
                    res_d   = Mul_Produto;
`ifdef MUL_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_RESP;
                end
`ifdef MUL_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                ptr_d   = win_q;
                gnt_d   = '0;
                state_d = S_CLEAR;
            end
            // Multipliers may hold Done after a result; only Idle proves they are free again.
            S_CLEAR: begin
                if (Mul_Idle) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_CLEAR;
            ptr_q   <= IW'(N_REQ - 1);
            win_q   <= '0;
            gnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

`ifdef MUL_ARB_TIMEOUT_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

    assign Gnt    = gnt_q;
    assign Ack    = (state_q == S_RESP) ? gnt_q : '0;
    assign Result = res_q;
    assign Busy   = (state_q != S_IDLE);
    assign Mul_St = (state_q == S_START);
    assign Mul_A  = a_q;
    assign Mul_B  = b_q;

endmodule
